debounce_sync: RTL and testbench

//  Input conditioning stage that drives d_in of the d_ff stage. It synchronises an

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/sync_chain.sv | 28 ++
 rtl/debounce_sync.sv | 119 +++++++++++
 tb/tb_debounce_sync.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce/synchroniser input stage.
//   db_state_t        : debounce FSM state encoding
//   DB_DEFAULT_CYCLES : default count of equal synced samples to accept a change
//   DB_DEFAULT_SYNC   : default synchroniser depth
//   db_state_level    : settled level implied by a state (stable or pending)
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      PEND_HI   = 2'b01,
      STABLE_HI = 2'b10,
      PEND_LO   = 2'b11
   } db_state_t;

   localparam int DB_DEFAULT_CYCLES = 4;
   localparam int DB_DEFAULT_SYNC   = 2;

   // Level currently presented on q_level while in the given state.
   function automatic logic db_state_level(input db_state_t st);
      logic lvl;
      case (st)
         STABLE_HI, PEND_LO: lvl = 1'b1;
         default:            lvl = 1'b0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input level
//   q_o   : synchronised level, STAGES clock edges after capture
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift register; stage 0 is the metastability-catching flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Input conditioning: synchronise an asynchronous level into clk, then debounce.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   d_in       : raw asynchronous level
//   q_level    : debounced synchronised level (registered)
//   rise_pulse : one-cycle strobe when q_level goes 0->1 (registered)
//   fall_pulse : one-cycle strobe when q_level goes 1->0 (registered)
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DB_DEFAULT_SYNC,
   parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic q_level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (d_in),
      .q_o   (s)
   );

   // State, counter and all outputs registered together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state: cnt counts consecutive synced samples disagreeing with the
   // settled level; any agreeing sample abandons the pending change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s) begin
               state_d = PEND_HI;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               state_d = PEND_LO;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            // Corrupted encoding: fall back to the reset state.
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = db_state_level(STABLE_LO);
         end
      endcase
   end

   assign q_level    = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed latency/glitch/reset scenarios, then a long
// random run, all compared against a delay-line + run-length reference model.
module tb_debounce_sync;

   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic clk;
   logic reset;
   logic d_in;
   logic q_level;
   logic rise_pulse;
   logic fall_pulse;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic m_level;
   logic m_rise;
   logic m_fall;
   int   run_len;
   logic dl[$];
   logic prev_q;

   debounce_sync #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .d_in       (d_in),
      .q_level    (q_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      dl.delete();
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      run_len = 0;
   endtask

   // The FSM sees d_in as it was SYNC edges earlier (zeros after reset); a
   // level change is accepted once DEB consecutive seen samples disagree.
   task automatic model_step();
      logic v;
      if (reset) begin
         model_reset();
      end else begin
         dl.push_back(d_in);
         v = 1'b0;
         if (dl.size() > SYNC) v = dl.pop_front();
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (v != m_level) begin
            run_len++;
            if (run_len == DEB) begin
               m_level = v;
               m_rise  = v;
               m_fall  = ~v;
               run_len = 0;
            end
         end else begin
            run_len = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Model comparison plus structural invariants on the outputs.
   task automatic observe(input string tag);
      chk({tag, "_model_q"}, q_level, m_level);
      chk({tag, "_model_rise"}, rise_pulse, m_rise);
      chk({tag, "_model_fall"}, fall_pulse, m_fall);
      chk({tag, "_pulse_onehot"}, rise_pulse & fall_pulse, 1'b0);
      if (rise_pulse) chk({tag, "_rise_change"}, q_level & ~prev_q, 1'b1);
      if (fall_pulse) chk({tag, "_fall_change"}, ~q_level & prev_q, 1'b1);
      chk({tag, "_cnt_bound"}, int'(dut.cnt_q) < DEB, 1'b1);
      prev_q = q_level;
   endtask

   // n edges with fixed expected outputs after each one.
   task automatic run(input int n, input logic eq, input logic er, input logic ef,
                      input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_q"}, q_level, eq);
         chk({tag, "_rise"}, rise_pulse, er);
         chk({tag, "_fall"}, fall_pulse, ef);
         observe(tag);
      end
   endtask

   initial begin
      int tog_max;
      model_reset();
      prev_q = 1'b0;
      reset  = 1'b1;
      d_in   = 1'b1;

      // 1: reset held with d_in high, then rise 6 edges after release
      run(3, 1'b0, 1'b0, 1'b0, "t1_in_reset");
      reset = 1'b0;
      run(5, 1'b0, 1'b0, 1'b0, "t1_wait");
      run(1, 1'b1, 1'b1, 1'b0, "t1_rise");
      run(1, 1'b1, 1'b0, 1'b0, "t1_after");

      // 2: fall then rise, each exactly 6 edges after the change
      d_in = 1'b0;
      run(5, 1'b1, 1'b0, 1'b0, "t2_wait_fall");
      run(1, 1'b0, 1'b0, 1'b1, "t2_fall");
      run(1, 1'b0, 1'b0, 1'b0, "t2_after_fall");
      d_in = 1'b1;
      run(5, 1'b0, 1'b0, 1'b0, "t2_wait_rise");
      run(1, 1'b1, 1'b1, 1'b0, "t2_rise");
      run(2, 1'b1, 1'b0, 1'b0, "t2_after_rise");

      // 3: back to low, then a 3-cycle glitch (rejected) and a 4-cycle pulse (accepted)
      d_in = 1'b0;
      run(5, 1'b1, 1'b0, 1'b0, "t3_setup");
      run(1, 1'b0, 1'b0, 1'b1, "t3_setup_fall");
      d_in = 1'b1;
      run(3, 1'b0, 1'b0, 1'b0, "t3_glitch3");
      d_in = 1'b0;
      run(10, 1'b0, 1'b0, 1'b0, "t3_rejected");
      d_in = 1'b1;
      run(4, 1'b0, 1'b0, 1'b0, "t3_pulse4");
      d_in = 1'b0;
      run(1, 1'b0, 1'b0, 1'b0, "t3_pulse4_wait");
      run(1, 1'b1, 1'b1, 1'b0, "t3_pulse4_rise");
      run(3, 1'b1, 1'b0, 1'b0, "t3_pulse4_high");
      run(1, 1'b0, 1'b0, 1'b1, "t3_pulse4_fall");
      run(1, 1'b0, 1'b0, 1'b0, "t3_pulse4_low");

      // 4: chatter from q_level=1, one fall 6 edges after settling
      d_in = 1'b1;
      run(5, 1'b0, 1'b0, 1'b0, "t4_setup");
      run(1, 1'b1, 1'b1, 1'b0, "t4_setup_rise");
      for (int i = 0; i < 4; i++) begin
         d_in = ~d_in;
         run(1, 1'b1, 1'b0, 1'b0, "t4_chatter");
      end
      d_in = 1'b0;
      run(5, 1'b1, 1'b0, 1'b0, "t4_settle");
      run(1, 1'b0, 1'b0, 1'b1, "t4_fall");
      run(3, 1'b0, 1'b0, 1'b0, "t4_after");

      // 5a: async reset mid-PEND_HI with cnt=2, debounce restarts after release
      d_in = 1'b1;
      run(4, 1'b0, 1'b0, 1'b0, "t5_pend");
      chk("t5_cnt_is_2", dut.cnt_q == 3'd2, 1'b1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("t5_async_q", q_level, 1'b0);
      chk("t5_async_cnt_cleared", dut.cnt_q == 3'd0, 1'b1);
      observe("t5_async");
      run(1, 1'b0, 1'b0, 1'b0, "t5_hold");
      reset = 1'b0;
      run(5, 1'b0, 1'b0, 1'b0, "t5_restart");
      run(1, 1'b1, 1'b1, 1'b0, "t5_rise");

      // 5b: async reset while rise_pulse and q_level are high
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("t5b_async_q", q_level, 1'b0);
      chk("t5b_async_rise", rise_pulse, 1'b0);
      observe("t5b_async");
      run(1, 1'b0, 1'b0, 1'b0, "t5b_hold");
      reset = 1'b0;
      run(5, 1'b0, 1'b0, 1'b0, "t5b_restart");
      run(1, 1'b1, 1'b1, 1'b0, "t5b_rise");
      run(1, 1'b1, 1'b0, 1'b0, "t5b_after");

      // 6: random input with varying toggle density and rare resets
      tog_max = 3;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc % 500 == 0) tog_max = int'($urandom_range(1, 9));
         if ($urandom_range(0, tog_max) == 0) d_in = ~d_in;
         reset = ($urandom_range(0, 2999) == 0);
         tick();
         observe("rnd");
      end
      reset = 1'b0;
      run(2, m_level, m_rise, m_fall, "rnd_tail");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
